// File: rtl/fp_rmul_pkg.sv
// fp_rmul_pkg
//   Shared types and helpers for the fp_rmul_pipe floating-point multiplier.
//   Holds the operand/result class enum, the per-stage header struct, and
//   the constant functions that derive the exponent bias and canonical NaN
//   pattern from the exponent and fraction widths.
//   Optional feature macro used by the multiplier: FP_RMUL_RNE_EN.
package fp_rmul_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_t;

  // Header carried by every pipeline stage. The width-dependent fields
  // (exponent, mantissa/product, tag) wrap this in each module because
  // their widths come from module parameters.
  typedef struct packed {
    logic      sign;
    fp_class_t cls;
  } fp_hdr_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical NaN: positive sign, all-ones exponent, fraction MSB set.
  // Returned in 64 bits; callers narrow it to their word width.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int frac_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

  // Subnormals (exp==0, frac!=0) are flushed, so they classify as zero.
  function automatic fp_class_t fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  // Class of the product, in special-case priority order:
  // NaN (including zero*Inf), then Inf, then zero.
  function automatic fp_class_t fp_combine(input fp_class_t ca, input fp_class_t cb);
    if (ca == CLS_NAN || cb == CLS_NAN) return CLS_NAN;
    if ((ca == CLS_ZERO && cb == CLS_INF) || (ca == CLS_INF && cb == CLS_ZERO)) return CLS_NAN;
    if (ca == CLS_INF || cb == CLS_INF) return CLS_INF;
    if (ca == CLS_ZERO || cb == CLS_ZERO) return CLS_ZERO;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_rmul_norm_round.sv
// fp_rmul_norm_round
//   Purely combinational normalise / round / pack stage of fp_rmul_pipe.
//   Build option: FP_RMUL_RNE_EN defined -> round-to-nearest-even,
//   undefined -> truncation (round toward zero).
// Ports:
//   hdr   in  sign and combined operand class of the product
//   es    in  signed exponent sum ea+eb-bias, EXP_W+2 bits
//   prod  in  unsigned mantissa product {1,fa}*{1,fb}, 2*FRAC_W+2 bits
//   res   out packed result {sign, exp, frac}
module fp_rmul_norm_round import fp_rmul_pkg::*; #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  fp_hdr_t                  hdr,
  input  logic [EXP_W+1:0]         es,
  input  logic [2*FRAC_W+1:0]      prod,
  output logic [EXP_W+FRAC_W:0]    res
);

  localparam int PW  = 2 * FRAC_W + 2;
  localparam int ESW = EXP_W + 2;
  localparam int W   = 1 + EXP_W + FRAC_W;

  localparam logic [W-1:0]          CANON_NAN = W'(fp_canon_nan(EXP_W, FRAC_W));
  localparam logic signed [ESW-1:0] EXP_ZERO  = '0;
  localparam logic signed [ESW-1:0] EXP_MAX   = ESW'((1 << EXP_W) - 1);

  logic                  msb;
  logic [PW-1:0]         norm;
  logic [FRAC_W-1:0]     frac_t;
  logic [FRAC_W-1:0]     frac_r;
  logic signed [ESW-1:0] es_s;
  logic signed [ESW-1:0] norm_inc;
  logic signed [ESW-1:0] exp_n;
  logic signed [ESW-1:0] exp_r;

  // Normalise: the product of two [1,2) mantissas lies in [1,4). With the
  // MSB set the value is in [2,4) and the exponent gains one; otherwise
  // shift left so the hidden 1 always sits at bit PW-1. The fraction is
  // then the FRAC_W bits right below the hidden 1.
  always_comb begin
    es_s     = $signed(es);
    msb      = prod[PW-1];
    norm     = msb ? prod : (prod << 1);
    frac_t   = FRAC_W'(norm >> (PW - 1 - FRAC_W));
    norm_inc = {{(ESW-1){1'b0}}, msb};
    exp_n    = es_s + norm_inc;
  end

`ifdef FP_RMUL_RNE_EN
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [FRAC_W:0]       frac_sum;
  logic signed [ESW-1:0] carry_inc;

  // Round to nearest, ties to even. When the increment carries out of the
  // fraction the low FRAC_W bits of the sum are already zero, so only the
  // exponent needs the extra +1.
  always_comb begin
    guard     = norm[PW-2-FRAC_W];
    sticky    = |norm[PW-3-FRAC_W:0];
    round_up  = guard & (sticky | frac_t[0]);
    frac_sum  = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
    frac_r    = frac_sum[FRAC_W-1:0];
    carry_inc = {{(ESW-1){1'b0}}, frac_sum[FRAC_W]};
    exp_r     = exp_n + carry_inc;
  end
`else
  // Truncation: the bits below the fraction are simply dropped.
  always_comb begin
    frac_r = frac_t;
    exp_r  = exp_n;
  end
`endif

  // Pack, with special results taking priority over the computed value.
  // Underflow flushes to signed zero; overflow saturates to signed Inf.
  always_comb begin
    res = {hdr.sign, exp_r[EXP_W-1:0], frac_r};
    if (hdr.cls == CLS_NAN) begin
      res = CANON_NAN;
    end else if (hdr.cls == CLS_INF) begin
      res = {hdr.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (hdr.cls == CLS_ZERO || exp_r <= EXP_ZERO) begin
      res = {hdr.sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if (exp_r >= EXP_MAX) begin
      res = {hdr.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
  end

endmodule

// File: rtl/fp_rmul_pipe.sv
// fp_rmul_pipe
//   Parametrised three-stage valid/ready floating-point multiplier with a
//   tag sideband. S0 unpacks/classifies, S1 multiplies mantissas, S2
//   normalises, rounds and packs. Fixed latency of 3 cycles; the pipeline
//   advances as one unit, so bubbles are carried rather than collapsed.
//   Build option: FP_RMUL_RNE_EN selects round-to-nearest-even (default is
//   truncation); latency and handshake are the same either way.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   in_valid   in   operand pair present
//   in_ready   out  operands accepted this cycle when in_valid is high
//   in_a/in_b  in   operands {sign, exp, frac}
//   in_tag     in   sideband carried with the operation
//   out_valid  out  result present
//   out_ready  in   consumer takes the result
//   out_res    out  product {sign, exp, frac}
//   out_tag    out  sideband aligned with out_res
module fp_rmul_pipe import fp_rmul_pkg::*; #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_a,
  input  logic [EXP_W+FRAC_W:0]   in_b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_res,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int MW   = FRAC_W + 1;
  localparam int PW   = 2 * FRAC_W + 2;
  localparam int ESW  = EXP_W + 2;
  localparam int BIAS = fp_bias(EXP_W);

  typedef struct packed {
    fp_hdr_t          hdr;
    logic [ESW-1:0]   es;
    logic [MW-1:0]    ma;
    logic [MW-1:0]    mb;
    logic [TAG_W-1:0] tag;
  } s0_t;

  typedef struct packed {
    fp_hdr_t          hdr;
    logic [ESW-1:0]   es;
    logic [PW-1:0]    prod;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic              advance;
  logic              s0_v;
  logic              s1_v;
  s0_t               s0_d;
  s0_t               s0_q;
  s1_t               s1_d;
  s1_t               s1_q;
  logic [W-1:0]      res_d;

  logic              sa;
  logic              sb;
  logic [EXP_W-1:0]  ea;
  logic [EXP_W-1:0]  eb;
  logic [FRAC_W-1:0] fa;
  logic [FRAC_W-1:0] fb;
  fp_class_t         ca;
  fp_class_t         cb;

  // The whole pipeline stalls only when a result is waiting and the
  // consumer refuses it; the input side sees exactly that condition.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S0 input decode. The exponent sum is kept signed and two bits wider
  // than a field so that underflow and overflow survive to S2.
  always_comb begin
    {sa, ea, fa} = in_a;
    {sb, eb, fb} = in_b;
    ca           = fp_classify(ea == '0, &ea, fa == '0);
    cb           = fp_classify(eb == '0, &eb, fb == '0);
    s0_d.hdr.sign = sa ^ sb;
    s0_d.hdr.cls  = fp_combine(ca, cb);
    s0_d.es       = {2'b00, ea} + {2'b00, eb} - ESW'(BIAS);
    s0_d.ma       = {1'b1, fa};
    s0_d.mb       = {1'b1, fb};
    s0_d.tag      = in_tag;
  end

  // S1 mantissa multiply; everything else rides along unchanged.
  always_comb begin
    s1_d.hdr  = s0_q.hdr;
    s1_d.es   = s0_q.es;
    s1_d.prod = PW'(s0_q.ma) * PW'(s0_q.mb);
    s1_d.tag  = s0_q.tag;
  end

  fp_rmul_norm_round #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_norm_round (
    .hdr  (s1_q.hdr),
    .es   (s1_q.es),
    .prod (s1_q.prod),
    .res  (res_d)
  );

  // Stage-valid bits. Reset drops every in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_v      <= 1'b0;
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      s0_v      <= in_valid;
      s1_v      <= s0_v;
      out_valid <= s1_v;
    end
  end

  // Stage data registers; contents are qualified by the valid bits, so
  // they need no reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  // Output register. Loaded only from a valid S1 entry so that it holds
  // the last result through bubbles and stays fixed while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_res <= '0;
      out_tag <= '0;
    end else if (advance && s1_v) begin
      out_res <= res_d;
      out_tag <= s1_q.tag;
    end
  end

endmodule

// File: doc/fp_rmul_pipe.md
Name: fp_rmul_pipe

Overview:
- Parametrised, valid/ready-pipelined floating-point multiplier.
- Generalises the fixed FP16 two-stage reduced multiplier to arbitrary exponent and fraction widths.
- Adds backpressure, a tag sideband, and overflow and special-value handling.
- Used by the generated-datapath floating-point library as a drop-in multiply resource with a fixed 3-cycle latency.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- FRAC_W, 10, stored fraction width.
- TAG_W, 4, opaque sideband width carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  1+EXP_W+FRAC_W  operand A, laid out {sign, exp, frac}.
- in_b  in  1+EXP_W+FRAC_W  operand B, same layout.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_res  out  1+EXP_W+FRAC_W  product.
- out_tag  out  TAG_W  sideband aligned with out_res.

Behaviour:
- Reset: rst==0 at a clk edge clears all three stage-valid bits.
  - out_valid=0, out_res=0, out_tag=0.
  - in_ready reads 1 on the first cycle after reset.
  - Reset mid-operation discards every in-flight operation; no result is ever emitted for it.
- Pipeline: S0 unpack/classify, S1 mantissa multiply, S2 normalise/round/pack.
  - Registered at every stage.
  - Latency is 3 cycles from an accepted input to out_valid when out_ready is held at 1.
- Handshake: advance = !out_valid || out_ready; in_ready = advance.
  - Input is accepted when in_valid && in_ready.
  - When advance==0 all stages hold. out_res and out_tag stay stable while out_valid && !out_ready.
  - Bubbles do not collapse; the pipeline moves as a single unit.
  - Throughput is 1 operation per cycle.
- S0 decode:
  - sign = sa^sb.
  - exp==0 means zero; subnormal inputs are flushed to zero.
  - exp all-ones with frac==0 means Inf; exp all-ones with frac!=0 means NaN.
  - Exponent sum es = ea+eb-bias, signed, EXP_W+2 bits.
- S1: P = {1,fa} * {1,fb}, 2*FRAC_W+2 bits, unsigned.
- S2 normalise:
  - If P MSB is set, use the top bits and es+1; otherwise shift left by 1.
  - Take the FRAC_W fraction bits, then apply rounding (see Optional Feature).
  - A rounding carry out of the fraction increments the exponent and zeroes the fraction.
- Special results, in priority order:
  - Any NaN, or zero*Inf: canonical NaN = {0, all-ones, 1 followed by zeros}.
  - Any Inf: signed Inf.
  - Any zero: signed zero.
  - Final exponent <= 0: signed zero (underflow flushes; no subnormal output).
  - Final exponent >= all-ones: signed Inf (overflow saturates).
- The tag travels unchanged through all stages.

Optional Feature:
- Macro FP_RMUL_RNE_EN.
- Defined: round-to-nearest-even using guard and sticky bits; ties go to an even LSB; the carry case is handled as above.
- Undefined: truncation (round toward zero); the guard/sticky logic is not built.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package fp_rmul_pkg holds:
  - Class enum ZERO/NORM/INF/NAN.
  - Bias and canonical-NaN constant functions of EXP_W/FRAC_W.
  - A per-stage struct (sign, class, exp, mantissa/product, tag).
- One natural sub-module, fp_rmul_norm_round: purely combinational normalise/round/pack logic, instantiated in S2.

Test Plan (defaults EXP_W=5, FRAC_W=10):
- Basic products, out_ready=1:
  - 0x3C00*0x3C00 -> 0x3C00 (1.0).
  - 0x3E00*0x3E00 -> 0x4080 (e16 f128).
  - 0x3D00*0x3D00 -> 0x3E40 (e15 f576).
  - 0x3A00*0x3A00 -> 0x3880 (e14 f128).
  - Each result arrives exactly 3 cycles after acceptance.
- Underflow and zero:
  - 0x0400*0x3800 (2^-14*0.5) -> 0x0000.
  - 0x8000*0x3C00 -> 0x8000.
- Specials and overflow:
  - 0x7BFF*0x7BFF -> 0x7C00.
  - 0x7C00*0x0000 -> 0x7E00.
  - 0xFC00*0x3C00 -> 0xFC00.
- Rounding: 0x3C01*0x3E00 -> 0x3E01 without FP_RMUL_RNE_EN; 0x3E02 with it (tie to even).
- Backpressure:
  - Stream 8 back-to-back ops with tags 0..7 while out_ready toggles randomly.
  - Results and tags emerge in order with no loss or duplication.
  - out_res is stable while stalled.
  - in_ready==0 exactly when out_valid && !out_ready.
- Reset: assert rst=0 with 3 ops in flight -> out_valid=0 on the next cycle, no stale results afterwards, and a new op completes in 3 cycles.
